// File: rtl/mtm_alu_ctrl_if.sv
// mtm_alu_ctrl_if: frame-in, ALU-core and frame-out signal bundle of the mtm_Alu controller
interface mtm_alu_ctrl_if;
  logic rx_valid;
  logic rx_type;
  logic [7:0] rx_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0] alu_op;
  logic alu_start;
  logic alu_done;
  logic [31:0] alu_c;
  logic [3:0] alu_flags;
  logic tx_valid;
  logic tx_type;
  logic [7:0] tx_data;
  logic tx_ready;
  modport master (
    input rx_valid, rx_type, rx_data, alu_done, alu_c, alu_flags, tx_ready,
    output alu_a, alu_b, alu_op, alu_start, tx_valid, tx_type, tx_data
  );
  modport slave (
    output rx_valid, rx_type, rx_data, alu_done, alu_c, alu_flags, tx_ready,
    input alu_a, alu_b, alu_op, alu_start, tx_valid, tx_type, tx_data
  );
endinterface

// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: collects and checks an mtm_Alu packet, launches the ALU core and queues the response bytes
module mtm_alu_ctrl #(
  parameter int TIMEOUT_CYC = 2000,
  parameter int DATA_BYTES = 8
) (
  input logic clk,
  input logic rst_n,
  mtm_alu_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {COLLECT, CHECK, EXEC, TX_DATA, TX_CTL, TX_ERR} state_t;
  state_t state, state_nx;
  logic [63:0] sr;
  logic [3:0] cnt, crc, flags;
  logic [2:0] op, err, chk_err;
  logic [31:0] c;
  logic [1:0] idx;
  logic [TW-1:0] tcnt;
  logic rx_dat, rx_cmd, full, acc;
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] r;
    r = '0;
    for (int i = 67; i >= 0; i--) r = {r[2:0], 1'b0} ^ ((d[i] ^ r[3]) ? 4'h3 : 4'h0);
    return r;
  endfunction
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] r;
    r = '0;
    for (int i = 36; i >= 0; i--) r = {r[1:0], 1'b0} ^ ((d[i] ^ r[2]) ? 3'h3 : 3'h0);
    return r;
  endfunction
  assign rx_dat = bus.rx_valid & ~bus.rx_type;
  assign rx_cmd = bus.rx_valid & bus.rx_type;
  assign full = cnt == 4'(DATA_BYTES);
  assign acc = bus.tx_valid & bus.tx_ready;
  // Legal opcodes are exactly those with op[1] clear
  assign chk_err = !full ? 3'b100 : crc != crc4({sr, 1'b1, op}) ? 3'b010 : op[1] ? 3'b001 : 3'b000;
  assign bus.alu_b = sr[63:32];
  assign bus.alu_a = sr[31:0];
  assign bus.alu_op = op;
  assign bus.alu_start = state == CHECK && chk_err == 3'b000;
  assign bus.tx_valid = state inside {TX_DATA, TX_CTL, TX_ERR};
  assign bus.tx_type = state inside {TX_CTL, TX_ERR};
  assign bus.tx_data = state == TX_DATA ? c[{~idx, 3'b000} +: 8] :
                       state == TX_CTL ? {1'b0, flags, crc3({c, 1'b0, flags})} :
                       state == TX_ERR ? {1'b1, err, err, ^{1'b1, err, err}} : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      COLLECT: state_nx = rx_cmd ? CHECK : (rx_dat && full) ? TX_ERR : COLLECT;
      CHECK: state_nx = chk_err == 3'b000 ? EXEC : TX_ERR;
      EXEC: state_nx = bus.alu_done ? TX_DATA : EXEC;
      TX_DATA: state_nx = (acc && idx == 2'd3) ? TX_CTL : TX_DATA;
      TX_CTL, TX_ERR: state_nx = acc ? COLLECT : state;
      default: state_nx = COLLECT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      tcnt <= '0;
      op <= '0;
      crc <= '0;
      err <= '0;
      c <= '0;
      flags <= '0;
      idx <= '0;
    end else begin
      if (state == COLLECT) begin
        if (rx_dat) begin
          sr <= {sr[55:0], bus.rx_data};
          cnt <= cnt + 4'd1;
        end
        if (rx_cmd) begin
          op <= bus.rx_data[6:4];
          crc <= bus.rx_data[3:0];
        end
        if (rx_dat && full) err <= 3'b100;
        tcnt <= (bus.rx_valid || cnt == '0 || tcnt == T_LAST) ? '0 : tcnt + 1'b1;
        if (!bus.rx_valid && cnt != '0 && tcnt == T_LAST) cnt <= '0;
      end else begin
        tcnt <= '0;
        if (state_nx == COLLECT) cnt <= '0;
      end
      if (state == CHECK) err <= chk_err;
      if (state == EXEC && bus.alu_done) begin
        c <= bus.alu_c;
        flags <= bus.alu_flags;
      end
      idx <= state != TX_DATA ? 2'd0 : acc ? idx + 2'd1 : idx;
    end
endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb_mtm_alu_ctrl: randomized bench for mtm_alu_ctrl, checked against a packet-level reference model
module tb_mtm_alu_ctrl;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mtm_alu_ctrl_if bus();
  mtm_alu_ctrl #(.TIMEOUT_CYC(TO), .DATA_BYTES(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_pass = 0;
  int n_chk = 0;
  logic [8:0] exp_q[$], got_q[$];
  logic [66:0] exp_ops[$], got_ops[$];
  logic [7:0] pk[$];
  bit arm_hold = 0;
  int hold = 0;
  int fixed_lat = 0;
  logic [2:0] good_ops[4] = '{3'b000, 3'b001, 3'b100, 3'b101};
  logic [2:0] bad_ops[4] = '{3'b010, 3'b011, 3'b110, 3'b111};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  // CRCs as polynomial long division of the zero-augmented message
  function automatic logic [3:0] crc4_ref(input logic [67:0] d);
    logic [71:0] v;
    v = {d, 4'b0};
    for (int i = 71; i >= 4; i--) if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction
  function automatic logic [2:0] crc3_ref(input logic [36:0] d);
    logic [39:0] v;
    v = {d, 3'b0};
    for (int i = 39; i >= 3; i--) if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
    return v[2:0];
  endfunction
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      3'b000: r = {1'b0, a & b};
      3'b001: r = {1'b0, a | b};
      3'b100: begin r = {1'b0, a} + {1'b0, b}; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      default: begin r = {1'b0, a} - {1'b0, b}; ov = (a[31] != b[31]) && (r[31] != a[31]); end
    endcase
    return {r[32], ov, r[31:0] == 32'd0, r[31], r[31:0]};
  endfunction
  function automatic logic [7:0] err_byte(input logic [2:0] e);
    logic [7:0] v;
    v = {1'b1, e, e, 1'b0};
    v[0] = ($countones(v) % 2) == 1;
    return v;
  endfunction
  function automatic logic [7:0] good_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    return {1'b0, op, crc4_ref({b, a, 1'b1, op})};
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] b);
    pk.delete();
    for (int i = 3; i >= 0; i--) pk.push_back(b[8*i +: 8]);
    for (int i = 3; i >= 0; i--) pk.push_back(a[8*i +: 8]);
  endtask
  task automatic send(input logic t, input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_type = t;
    bus.rx_data = d;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_type = 1'($urandom);
    bus.rx_data = 8'($urandom);
  endtask
  task automatic predict(input logic [7:0] d[$], input logic [7:0] cmd, output bit ok);
    logic [31:0] a, b;
    logic [35:0] r;
    logic [2:0] e;
    e = 3'b000;
    a = '0;
    b = '0;
    if (d.size() != 8) e = 3'b100;
    else begin
      b = {d[0], d[1], d[2], d[3]};
      a = {d[4], d[5], d[6], d[7]};
      if (cmd[3:0] != crc4_ref({b, a, 1'b1, cmd[6:4]})) e = 3'b010;
      else if (!(cmd[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) e = 3'b001;
    end
    ok = e == 3'b000;
    if (!ok) exp_q.push_back({1'b1, err_byte(e)});
    else begin
      r = alu_ref(a, b, cmd[6:4]);
      exp_ops.push_back({a, b, cmd[6:4]});
      for (int k = 3; k >= 0; k--) exp_q.push_back({1'b0, r[8*k +: 8]});
      exp_q.push_back({1'b1, 1'b0, r[35:32], crc3_ref({r[31:0], 1'b0, r[35:32]})});
    end
  endtask
  task automatic settle();
    int n;
    n = 0;
    while ((got_q.size() < exp_q.size() || bus.tx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 400), 1);
    repeat (10) @(negedge clk);
    check("tx_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) check("tx_byte", got_q[i], exp_q[i]);
    check("start_count", got_ops.size(), exp_ops.size());
    foreach (exp_ops[i]) if (i < got_ops.size()) begin
      check("alu_a", got_ops[i][66:35], exp_ops[i][66:35]);
      check("alu_b", got_ops[i][34:3], exp_ops[i][34:3]);
      check("alu_op", got_ops[i][2:0], exp_ops[i][2:0]);
    end
    exp_q.delete();
    got_q.delete();
    exp_ops.delete();
    got_ops.delete();
    tick();
  endtask
  task automatic run_pkt(input logic [7:0] d[$], input bit has_cmd, input logic [7:0] cmd, input bit inject);
    bit ok;
    predict(d, cmd, ok);
    foreach (d[i]) begin
      if (i > 0) repeat ($urandom_range(0, 2)) tick();
      send(1'b0, d[i]);
    end
    if (has_cmd) begin
      repeat ($urandom_range(0, 2)) tick();
      send(1'b1, cmd);
      @(negedge clk);
      check("alu_start", bus.alu_start, 64'(ok));
      if (!ok) begin
        @(negedge clk);
        check("err_latency", bus.tx_valid, 1);
      end
      if (inject) begin
        tick();
        send(1'b0, 8'($urandom));
      end
    end else if (d.size() > 8) begin
      @(negedge clk);
      check("err_latency", bus.tx_valid, 1);
    end
    settle();
  endtask
  task automatic chk_reset(input string t);
    check({t, "_alu_a"}, bus.alu_a, 0);
    check({t, "_alu_b"}, bus.alu_b, 0);
    check({t, "_alu_op"}, bus.alu_op, 0);
    check({t, "_alu_start"}, bus.alu_start, 0);
    check({t, "_tx_valid"}, bus.tx_valid, 0);
    check({t, "_tx_type"}, bus.tx_type, 0);
    check({t, "_tx_data"}, bus.tx_data, 0);
  endtask
  initial begin
    logic [8:0] prev;
    bit stall;
    stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n && stall) begin
        check("hold_valid", bus.tx_valid, 1);
        check("hold_data", {bus.tx_type, bus.tx_data}, prev);
      end
      stall = rst_n && bus.tx_valid && !bus.tx_ready;
      prev = {bus.tx_type, bus.tx_data};
      if (rst_n && bus.tx_valid && bus.tx_ready) got_q.push_back(prev);
    end
  end
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      tick();
      if (arm_hold && bus.tx_valid && !bus.tx_type) begin
        arm_hold = 0;
        hold = 5;
      end
      if (hold > 0) begin
        bus.tx_ready = 1'b0;
        hold--;
      end else bus.tx_ready = $urandom_range(0, 3) != 0;
    end
  end
  initial begin
    logic [35:0] r;
    int lat;
    bus.alu_done = 1'b0;
    bus.alu_c = '0;
    bus.alu_flags = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_start) begin
        got_ops.push_back({bus.alu_a, bus.alu_b, bus.alu_op});
        r = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
        lat = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 6));
        repeat (lat) tick();
        bus.alu_done = 1'b1;
        bus.alu_c = r[31:0];
        bus.alu_flags = r[35:32];
        tick();
        bus.alu_done = 1'b0;
        bus.alu_c = $urandom;
        bus.alu_flags = 4'($urandom);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, b;
    logic [7:0] cmd;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_type = 1'b0;
    bus.rx_data = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    tick();
    rst_n = 1'b1;
    tick();
    a = 32'h11111111;
    b = 32'h22222222;
    load(a, b);
    run_pkt(pk, 1, good_cmd(a, b, 3'b100), 1);
    run_pkt(pk, 1, {1'b0, 3'b100, 4'h0}, 0);
    run_pkt(pk, 1, good_cmd(a, b, 3'b010), 0);
    void'(pk.pop_back());
    run_pkt(pk, 1, good_cmd(a, b, 3'b100), 0);
    load(a, b);
    pk.push_back(8'h5a);
    run_pkt(pk, 0, 8'h00, 0);
    repeat (4) send(1'b0, 8'($urandom));
    repeat (TO) tick();
    a = $urandom;
    b = $urandom;
    load(a, b);
    run_pkt(pk, 1, good_cmd(a, b, 3'b101), 0);
    arm_hold = 1;
    run_pkt(pk, 1, good_cmd(a, b, 3'b100), 0);
    check("hold_armed", 64'(arm_hold), 0);
    fixed_lat = 4;
    exp_ops.push_back({a, b, 3'b100});
    foreach (pk[i]) send(1'b0, pk[i]);
    send(1'b1, good_cmd(a, b, 3'b100));
    @(negedge clk);
    check("alu_start", bus.alu_start, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid");
    tick();
    rst_n = 1'b1;
    settle();
    fixed_lat = 0;
    a = 32'hffffffff;
    b = 32'h0;
    load(a, b);
    run_pkt(pk, 1, good_cmd(a, b, 3'b001), 0);
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      b = $urandom;
      load(a, b);
      case ($urandom_range(0, 5))
        0, 1, 2: run_pkt(pk, 1, good_cmd(a, b, good_ops[$urandom_range(0, 3)]), 0);
        3: begin
          cmd = good_cmd(a, b, good_ops[$urandom_range(0, 3)]);
          cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
          run_pkt(pk, 1, cmd, 0);
        end
        4: run_pkt(pk, 1, good_cmd(a, b, bad_ops[$urandom_range(0, 3)]), 0);
        default: begin
          n = $urandom_range(0, 9);
          if (n == 8) n = 9;
          while (pk.size() > n) void'(pk.pop_back());
          while (pk.size() < n) pk.push_back(8'($urandom));
          run_pkt(pk, n != 9, 8'($urandom), 0);
        end
      endcase
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
